// File: rtl/da_pkg.sv
// rtl/da_pkg.sv - shared defaults and mode encodings for the D/A capture buffer
package da_pkg;

   localparam int DA_DW      = 8;
   localparam int DA_NCH     = 3;
   localparam int DA_LINENUM = 9;
   localparam int DA_AW      = 10;
   localparam int DA_CW      = 2;
   localparam int DA_LCW     = 16;

   localparam logic DA_MODE_ONESHOT = 1'b0;
   localparam logic DA_MODE_RING    = 1'b1;

   // Index width for a memory of the given depth; a depth of 1 still needs one bit.
   function automatic int da_idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/da_chan_mem.sv
// rtl/da_chan_mem.sv - one channel of sample storage, sync write, sync read-before-write
module da_chan_mem #(
   parameter int DW    = 8,
   parameter int DEPTH = 9,
   parameter int IW    = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [IW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   input  logic [IW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read sees the pre-write content when both ports hit the same index.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/da_capture_buffer.sv
// rtl/da_capture_buffer.sv - multi-channel D/A line capture buffer with readback
module da_capture_buffer
   import da_pkg::*;
#(
   parameter int DW      = DA_DW,
   parameter int NCH     = DA_NCH,
   parameter int LINENUM = DA_LINENUM,
   parameter int AW      = DA_AW,
   parameter int CW      = DA_CW
) (
   input  logic                dack,
   input  logic                reset,
   input  logic                we,
   input  logic [NCH*DW-1:0]   din,
   input  logic                line_start,
   input  logic                mode,
   input  logic                rd_en,
   input  logic [CW-1:0]       rd_ch,
   input  logic [AW-1:0]       rd_addr,
   output logic [DW-1:0]       rd_data,
   output logic                rd_valid,
   output logic [AW-1:0]       wr_addr,
   output logic                full,
   output logic                ovf,
   output logic                line_done,
   output logic [DA_LCW-1:0]   line_cnt
);

   localparam int              IW      = da_idx_width(LINENUM);
   localparam logic [AW-1:0]   LAST    = AW'(LINENUM - 1);
   localparam logic [CW:0]     NCH_LIM = (CW + 1)'(NCH);
   localparam logic [AW:0]     LN_LIM  = (AW + 1)'(LINENUM);

   logic          wr_fire;
   logic [AW-1:0] wr_idx;
   logic          wr_last;
   logic          rd_in_range;
   logic [CW-1:0] rd_sel_q;
   logic          rd_zero_q;
   logic [DW-1:0] ch_q [NCH];

   // line_start rewinds the pointer before the same-cycle write is placed.
   always_comb begin
      wr_idx      = line_start ? '0 : wr_addr;
      wr_fire     = we && (line_start || !full);
      wr_last     = (wr_idx == LAST);
      rd_in_range = ({1'b0, rd_ch} < NCH_LIM) && ({1'b0, rd_addr} < LN_LIM);
   end

   always_ff @(posedge dack or negedge reset) begin
      if (!reset) begin
         wr_addr   <= '0;
         full      <= 1'b0;
         ovf       <= 1'b0;
         line_done <= 1'b0;
         line_cnt  <= '0;
      end else begin
         line_done <= 1'b0;
         if (line_start) begin
            wr_addr <= '0;
            full    <= 1'b0;
            ovf     <= 1'b0;
         end
         if (wr_fire) begin
            if (wr_last) begin
               wr_addr   <= '0;
               line_done <= 1'b1;
               line_cnt  <= line_cnt + 1'b1;
               if (mode == DA_MODE_ONESHOT) begin
                  full <= 1'b1;
               end
            end else begin
               wr_addr <= wr_idx + 1'b1;
            end
         end else if (we) begin
            ovf <= 1'b1;
         end
      end
   end

   for (genvar k = 0; k < NCH; k++) begin : g_chan
      da_chan_mem #(
         .DW    (DW),
         .DEPTH (LINENUM),
         .IW    (IW)
      ) u_mem (
         .clk     (dack),
         .reset   (reset),
         .we      (wr_fire),
         .wr_addr (wr_idx[IW-1:0]),
         .wr_data (din[k*DW +: DW]),
         .rd_en   (rd_en && rd_in_range && (rd_ch == CW'(k))),
         .rd_addr (rd_addr[IW-1:0]),
         .rd_data (ch_q[k])
      );
   end

   // Selection is captured with the request so rd_data holds while rd_en is low.
   always_ff @(posedge dack or negedge reset) begin
      if (!reset) begin
         rd_valid  <= 1'b0;
         rd_sel_q  <= '0;
         rd_zero_q <= 1'b1;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            rd_sel_q  <= rd_ch;
            rd_zero_q <= !rd_in_range;
         end
      end
   end

   always_comb begin
      rd_data = '0;
      if (!rd_zero_q) begin
         for (int k = 0; k < NCH; k++) begin
            if (rd_sel_q == CW'(k)) begin
               rd_data = ch_q[k];
            end
         end
      end
   end

endmodule

// File: tb/tb_da_capture_buffer.sv
// tb/tb_da_capture_buffer.sv - directed and random checks of da_capture_buffer against a line model
module tb_da_capture_buffer;

   localparam int DW = 8;
   localparam int NCH = 3;
   localparam int LN = 9;
   localparam int AW = 10;
   localparam int CW = 2;

   logic              dack = 1'b0;
   logic              reset = 1'b0;
   logic              we = 1'b0;
   logic [NCH*DW-1:0] din = '0;
   logic              line_start = 1'b0;
   logic              mode = 1'b0;
   logic              rd_en = 1'b0;
   logic [CW-1:0]     rd_ch = '0;
   logic [AW-1:0]     rd_addr = '0;
   logic [DW-1:0]     rd_data;
   logic              rd_valid;
   logic [AW-1:0]     wr_addr;
   logic              full;
   logic              ovf;
   logic              line_done;
   logic [15:0]       line_cnt;

   int errors = 0;
   int checks = 0;

   // Reference model: line contents plus the visible line state.
   logic [DW-1:0] m_mem [NCH][LN];
   bit            m_known [NCH][LN];
   int            m_wa, m_lc;
   bit            m_full, m_ovf, m_ld, m_rv, m_rd_known;
   logic [DW-1:0] m_rd;

   da_capture_buffer #(.DW(DW), .NCH(NCH), .LINENUM(LN), .AW(AW), .CW(CW)) dut (
      .dack(dack), .reset(reset), .we(we), .din(din), .line_start(line_start),
      .mode(mode), .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_valid(rd_valid), .wr_addr(wr_addr), .full(full),
      .ovf(ovf), .line_done(line_done), .line_cnt(line_cnt)
   );

   always #5 dack = ~dack;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_wa = 0; m_lc = 0; m_full = 0; m_ovf = 0; m_ld = 0;
      m_rv = 0; m_rd = '0; m_rd_known = 1;
      for (int c = 0; c < NCH; c++)
         for (int a = 0; a < LN; a++) m_known[c][a] = 0;
   endtask

   task automatic check_all();
      check("wr_addr", 32'(wr_addr), 32'(m_wa));
      check("full", 32'(full), 32'(m_full));
      check("ovf", 32'(ovf), 32'(m_ovf));
      check("line_done", 32'(line_done), 32'(m_ld));
      check("line_cnt", 32'(line_cnt), 32'(m_lc[15:0]));
      check("rd_valid", 32'(rd_valid), 32'(m_rv));
      if (m_rd_known) check("rd_data", 32'(rd_data), 32'(m_rd));
   endtask

   // One dack cycle: apply inputs, advance the model, compare after the edge.
   task automatic step(input logic i_we, input logic [NCH*DW-1:0] i_din, input logic i_ls,
                       input logic i_mode, input logic i_rd, input int i_ch, input int i_addr);
      we = i_we; din = i_din; line_start = i_ls; mode = i_mode;
      rd_en = i_rd; rd_ch = CW'(i_ch); rd_addr = AW'(i_addr);
      m_ld = 0;
      m_rv = i_rd;
      if (i_rd) begin
         if (i_ch < NCH && i_addr < LN) begin
            m_rd = m_mem[i_ch][i_addr];
            m_rd_known = m_known[i_ch][i_addr];
         end else begin
            m_rd = '0;
            m_rd_known = 1;
         end
      end
      if (i_ls) begin
         m_wa = 0; m_full = 0; m_ovf = 0;
      end
      if (i_we) begin
         if (!m_full) begin
            for (int c = 0; c < NCH; c++) begin
               m_mem[c][m_wa] = i_din[c*DW +: DW];
               m_known[c][m_wa] = 1;
            end
            m_wa = m_wa + 1;
            if (m_wa == LN) begin
               m_wa = 0; m_ld = 1; m_lc = (m_lc + 1) % 65536;
               if (i_mode == 1'b0) m_full = 1;
            end
         end else begin
            m_ovf = 1;
         end
      end
      @(posedge dack);
      #1;
      check_all();
   endtask

   initial begin : main
      int lc0;
      model_reset();
      repeat (2) @(posedge dack);
      #1;
      check_all();
      reset = 1'b1;

      // Async reset mid-line
      for (int i = 0; i < 4; i++) step(1'b1, 24'h112233 + 24'(i), 1'b0, 1'b0, 1'b0, 0, 0);
      check("t1_wr_addr_pre", 32'(wr_addr), 32'd4);
      #2 reset = 1'b0;
      #1;
      model_reset();
      check_all();
      check("t1_wr_addr_async", 32'(wr_addr), 32'd0);
      @(posedge dack);
      #1 reset = 1'b1;

      // One-shot line fill
      for (int i = 0; i < LN; i++) step(1'b1, 24'h0A0B0C + 24'(i), 1'b0, 1'b0, 1'b0, 0, 0);
      check("t2_line_done", 32'(line_done), 32'd1);
      check("t2_full", 32'(full), 32'd1);
      check("t2_line_cnt", 32'(line_cnt), 32'd1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1, 8);
      check("t2_rd_ch1_idx8", 32'(rd_data), 32'h0B);
      check("t2_rd_valid", 32'(rd_valid), 32'd1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 0, 0);
      check("t2_rd_hold", 32'(rd_data), 32'h0B);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, 0, 8);
      check("t2_rd_ch0_idx8", 32'(rd_data), 32'h14);

      // Overflow while full, then line_start clears
      step(1'b1, 24'hDEADBE, 1'b0, 1'b0, 1'b0, 0, 0);
      step(1'b1, 24'hDEADBE, 1'b0, 1'b0, 1'b1, 2, 0);
      check("t3_ovf", 32'(ovf), 32'd1);
      check("t3_wr_addr", 32'(wr_addr), 32'd0);
      check("t3_mem_kept", 32'(rd_data), 32'h0A);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0, 0, 0);
      check("t3_ls_full", 32'(full), 32'd0);
      check("t3_ls_ovf", 32'(ovf), 32'd0);

      // Ring mode
      lc0 = m_lc;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 24'(i * 7 + 3), 1'b0, 1'b1, 1'b0, 0, 0);
         if (i == 8 || i == 17) check("t4_line_done_pulse", 32'(line_done), 32'd1);
      end
      check("t4_line_cnt", 32'(line_cnt), 32'(lc0 + 2));
      check("t4_wr_addr", 32'(wr_addr), 32'd2);
      check("t4_full", 32'(full), 32'd0);

      // line_start + write while full
      step(1'b0, '0, 1'b1, 1'b0, 1'b0, 0, 0);
      for (int i = 0; i < LN; i++) step(1'b1, 24'h500000 + 24'(i), 1'b0, 1'b0, 1'b0, 0, 0);
      step(1'b1, 24'h0F0E0D, 1'b1, 1'b0, 1'b0, 0, 0);
      check("t5_wr_addr", 32'(wr_addr), 32'd1);
      check("t5_ovf", 32'(ovf), 32'd0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, 2, 0);
      check("t5_idx0", 32'(rd_data), 32'h0F);

      // Read-during-write and out-of-range reads
      step(1'b1, 24'h010203, 1'b0, 1'b0, 1'b0, 0, 0);
      step(1'b1, 24'h040506, 1'b0, 1'b0, 1'b0, 0, 0);
      check("t6_wr_addr", 32'(wr_addr), 32'd3);
      step(1'b1, 24'hAABBCC, 1'b0, 1'b0, 1'b1, 0, 3);
      check("t6_old_value", 32'(rd_data), 32'h03);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, 0, 3);
      check("t6_new_value", 32'(rd_data), 32'hCC);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, 3, 2);
      check("t6_bad_ch", 32'(rd_data), 32'd0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1, 3);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1, 9);
      check("t6_bad_addr", 32'(rd_data), 32'd0);

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 24'($urandom),
              ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
              1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 10)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
